// File: rtl/obi_manager.sv
`default_nettype none
// ============================================================================
//  Module   : obi_manager
//  Purpose  : Single-port OBI manager. Accepts commands on a valid/ready
//             stream, issues them as OBI A-channel requests, and returns the
//             R-channel responses on a registered valid/ready port. Every
//             response is tagged with the direction of its transaction.
//  Ports    : clk_i/reset_i          clock, synchronous active-high reset
//             cmd_*                  command stream (addr, we, be, wdata)
//             rsp_*                  response stream (rdata, err, we)
//             obi_*                  OBI A/R channel towards the subordinate
//             busy_o                 any transaction pending in the block
//             proto_err_o            sticky: rvalid with nothing outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module obi_manager #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  // command stream
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  // response stream
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_we_o,
  // OBI A channel
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  // OBI R channel
  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i,
  // status
  output logic                    busy_o,
  output logic                    proto_err_o
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  // A stage
  logic                   a_valid_q;
  logic [ADDR_WIDTH-1:0]  a_addr_q;
  logic                   a_we_q;
  logic [BE_WIDTH-1:0]    a_be_q;
  logic [DATA_WIDTH-1:0]  a_wdata_q;

  // outstanding tracking; tag_q[0] is always the oldest transaction
  logic [CNT_WIDTH-1:0]       outstanding_q;
  logic [CNT_WIDTH-1:0]       outstanding_d;
  logic [CNT_WIDTH-1:0]       wr_idx;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [MAX_OUTSTANDING-1:0] tag_d;

  // R stage
  logic                   rsp_valid_q;
  logic                   rsp_we_q;
  logic                   rsp_err_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   proto_err_q;

  logic cmd_fire;
  logic a_fire;
  logic r_fire;
  logic r_pop;
  logic r_spurious;

  assign cmd_ready_o  = !a_valid_q && (outstanding_q < MAX_CNT);
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign a_fire       = a_valid_q && obi_gnt_i;
  assign obi_rready_o = !rsp_valid_q || rsp_ready_i;
  assign r_fire       = obi_rvalid_i && obi_rready_o;
  assign r_pop        = r_fire && (outstanding_q != '0);
  assign r_spurious   = r_fire && (outstanding_q == '0);

  assign obi_req_o    = a_valid_q;
  assign obi_addr_o   = a_addr_q;
  assign obi_we_o     = a_we_q;
  assign obi_be_o     = a_be_q;
  assign obi_wdata_o  = a_wdata_q;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_we_o     = rsp_we_q;
  assign busy_o       = a_valid_q || (outstanding_q != '0) || rsp_valid_q;
  assign proto_err_o  = proto_err_q;

  // The new tag lands just above the surviving entries: when a pop happens in
  // the same cycle the queue shifts down first, so the slot moves down by one.
  // A push only happens while a_valid_q is set, which cmd_ready_o allowed only
  // with outstanding_q < MAX, so wr_idx always stays in range.
  assign wr_idx = outstanding_q - CNT_WIDTH'(r_pop);

  always_comb begin
    tag_d = tag_q;
    if (r_pop) begin
      tag_d = tag_q >> 1;
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (a_fire && (CNT_WIDTH'(i) == wr_idx)) begin
        tag_d[i] = a_we_q;
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (a_fire && !r_pop) begin
      outstanding_d = outstanding_q + CNT_WIDTH'(1);
    end else if (!a_fire && r_pop) begin
      outstanding_d = outstanding_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_valid_q     <= 1'b0;
      a_addr_q      <= '0;
      a_we_q        <= 1'b0;
      a_be_q        <= '0;
      a_wdata_q     <= '0;
      outstanding_q <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_we_q      <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      // cmd_fire and a_fire are mutually exclusive (ready needs !a_valid_q)
      if (cmd_fire) begin
        a_valid_q <= 1'b1;
        a_addr_q  <= cmd_addr_i;
        a_we_q    <= cmd_we_i;
        a_be_q    <= cmd_be_i;
        a_wdata_q <= cmd_wdata_i;
      end else if (a_fire) begin
        a_valid_q <= 1'b0;
      end

      outstanding_q <= outstanding_d;
      tag_q         <= tag_d;

      if (r_pop) begin
        rsp_valid_q <= 1'b1;
        rsp_we_q    <= tag_q[0];
        rsp_err_q   <= obi_err_i;
        rsp_rdata_q <= tag_q[0] ? '0 : obi_rdata_i;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end

      if (r_spurious) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obi_manager
//  Purpose  : Self-checking bench for obi_manager. A subordinate model with
//             its own memory answers the OBI side; a reference memory updated
//             in command order predicts every response into a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obi_manager;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic        cmd_we_i;
  logic [3:0]  cmd_be_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_we_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic        obi_rready_o;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;
  logic        busy_o;
  logic        proto_err_o;

  obi_manager #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_we_i     (cmd_we_i),
    .cmd_be_i     (cmd_be_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_we_o     (rsp_we_o),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_rready_o (obi_rready_o),
    .obi_rdata_i  (obi_rdata_i),
    .obi_err_i    (obi_err_i),
    .busy_o       (busy_o),
    .proto_err_o  (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  cmd_t        cmdq[$];   // accepted, not yet granted
  rsp_t        expq[$];   // predicted responses, in command order
  rsp_t        pendq[$];  // granted, awaiting rvalid handshake
  logic [31:0] ref_mem[32];
  logic [31:0] sub_mem[32];

  int checks     = 0;
  int errors     = 0;
  int gnt_pct    = 100;
  int rv_pct     = 100;
  int rr_pct     = 100;
  int spur_req   = 0;
  int spur_done  = 0;
  int req_cycles = 0;
  bit rv_busy    = 1'b0;
  bit lat_chk    = 1'b0;

  // Address map of the subordinate: word index = addr[6:2];
  // words 16..31 (addr[6]=1) answer with err and ignore writes.
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA5A50000 | (32'(i) * 32'h0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // -------------------------------------------------------------------------
  // Subordinate model + monitor. Samples on the falling edge, drives its
  // inputs 1 time unit after the rising edge.
  // -------------------------------------------------------------------------
  initial begin : sub
    rsp_t        r;
    logic [4:0]  idx;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = '0;
    obi_err_i    = 1'b0;
    rsp_ready_i  = 1'b1;
    for (int i = 0; i < 32; i++) sub_mem[i] = init_word(i);
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        cmdq.delete();
        expq.delete();
        pendq.delete();
        rv_busy = 1'b0;
        lat_chk = 1'b0;
      end else begin
        // outputs implied by what has been accepted/granted/answered so far
        chk("cmd_ready", cmd_ready_o, (cmdq.size() == 0) && (pendq.size() < MAXO));
        chk("obi_req", obi_req_o, cmdq.size() != 0);
        if (lat_chk) begin
          chk("rsp_latency", rsp_valid_o, 1'b1);
          lat_chk = 1'b0;
        end
        if (obi_req_o) req_cycles++;
        if (obi_req_o && cmdq.size() != 0) begin
          chk("a_addr",  obi_addr_o,  cmdq[0].addr);
          chk("a_we",    obi_we_o,    cmdq[0].we);
          chk("a_be",    obi_be_o,    cmdq[0].be);
          chk("a_wdata", obi_wdata_o, cmdq[0].wdata);
        end
        // response port
        if (rsp_valid_o && rsp_ready_i) begin
          if (expq.size() == 0) begin
            fail_now("rsp_unexpected");
          end else begin
            r = expq.pop_front();
            chk("rsp_we",    rsp_we_o,    r.we);
            chk("rsp_rdata", rsp_rdata_o, r.rdata);
            chk("rsp_err",   rsp_err_o,   r.err);
          end
        end
        // R channel handshake on the coming edge
        if (obi_rvalid_i && obi_rready_o && rv_busy) begin
          void'(pendq.pop_front());
          rv_busy = 1'b0;
          lat_chk = 1'b1;
        end
        // A channel handshake on the coming edge
        if (obi_req_o && obi_gnt_i && cmdq.size() != 0) begin
          void'(cmdq.pop_front());
          idx   = obi_addr_o[6:2];
          r.we  = obi_we_o;
          r.err = obi_addr_o[6];
          r.rdata = obi_we_o ? $urandom : sub_mem[idx];
          if (obi_we_o && !obi_addr_o[6]) sub_mem[idx] = merge(sub_mem[idx], obi_wdata_o, obi_be_o);
          pendq.push_back(r);
        end
      end

      @(posedge clk_i);
      #1;
      obi_gnt_i   = ($urandom_range(0, 99) < gnt_pct);
      rsp_ready_i = ($urandom_range(0, 99) < rr_pct);
      if (!rv_busy) begin
        if (pendq.size() != 0 && $urandom_range(0, 99) < rv_pct) begin
          obi_rvalid_i = 1'b1;
          obi_rdata_i  = pendq[0].rdata;
          obi_err_i    = pendq[0].err;
          rv_busy      = 1'b1;
        end else if (spur_done != spur_req) begin
          obi_rvalid_i = 1'b1;
          obi_rdata_i  = $urandom;
          obi_err_i    = 1'b0;
          spur_done++;
        end else begin
          obi_rvalid_i = 1'b0;
          obi_rdata_i  = $urandom;
          obi_err_i    = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Command driver with reference model
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d);
    bit   hs;
    int   n;
    cmd_t c;
    rsp_t e;
    logic [4:0] idx;
    step(1);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_we_i    = w;
    cmd_be_i    = b;
    cmd_wdata_i = d;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 500) begin
      @(negedge clk_i);
      hs = cmd_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    cmd_valid_i = 1'b0;
    if (!hs) begin
      fail_now("cmd_accept");
    end else begin
      idx     = a[6:2];
      e.we    = w;
      e.err   = a[6];
      e.rdata = w ? 32'h0 : ref_mem[idx];
      if (w && !a[6]) ref_mem[idx] = merge(ref_mem[idx], d, b);
      c.addr  = a;
      c.we    = w;
      c.be    = b;
      c.wdata = d;
      expq.push_back(e);
      cmdq.push_back(c);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy_o) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 2000) fail_now("drain");
  endtask

  task automatic check_reset(input string t);
    chk({t, "_req"},       obi_req_o,    1'b0);
    chk({t, "_rsp_valid"}, rsp_valid_o,  1'b0);
    chk({t, "_rsp_rdata"}, rsp_rdata_o,  32'h0);
    chk({t, "_rsp_err"},   rsp_err_o,    1'b0);
    chk({t, "_rsp_we"},    rsp_we_o,     1'b0);
    chk({t, "_busy"},      busy_o,       1'b0);
    chk({t, "_proto"},     proto_err_o,  1'b0);
    chk({t, "_cmd_ready"}, cmd_ready_o,  1'b1);
    chk({t, "_rready"},    obi_rready_o, 1'b1);
  endtask

  initial begin : main
    int          r0;
    logic [4:0]  idx;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_we_i    = 1'b0;
    cmd_be_i    = '0;
    cmd_wdata_i = '0;
    reset_i     = 1'b1;
    step(3);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_reset("rst");

    // single read, immediate grant, rvalid one cycle later
    r0 = req_cycles;
    send(32'h10, 1'b0, 4'hF, 32'h0);
    wait_idle();
    chk("single_req_cycles", 32'(req_cycles - r0), 32'd1);
    chk("single_busy", busy_o, 1'b0);

    // write then read of the same word
    send(32'h4, 1'b1, 4'b0011, 32'h12345678);
    send(32'h4, 1'b0, 4'hF, 32'h0);
    wait_idle();

    // grant stall: pins held, req held, no new command accepted
    gnt_pct = 0;
    send(32'h8, 1'b1, 4'b1010, 32'hCAFEF00D);
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_req",   obi_req_o,   1'b1);
      chk("stall_ready", cmd_ready_o, 1'b0);
      chk("stall_addr",  obi_addr_o,  32'h8);
      chk("stall_be",    obi_be_o,    4'b1010);
      chk("stall_wdata", obi_wdata_o, 32'hCAFEF00D);
    end
    gnt_pct = 100;
    wait_idle();

    // outstanding limit
    rv_pct = 0;
    send(32'h20, 1'b0, 4'hF, 32'h0);
    send(32'h24, 1'b0, 4'hF, 32'h0);
    step(3);
    @(negedge clk_i);
    chk("limit_ready", cmd_ready_o, 1'b0);
    chk("limit_busy",  busy_o,      1'b1);
    rv_pct = 100;
    @(negedge clk_i);        // one rvalid handshake lands on the next edge
    rv_pct = 0;
    chk("limit_ready_pre", cmd_ready_o, 1'b0);
    @(negedge clk_i);
    chk("limit_ready_post", cmd_ready_o, 1'b1);
    rv_pct = 100;
    wait_idle();

    // response backpressure
    rr_pct = 0;
    send(32'h30, 1'b0, 4'hF, 32'h0);
    send(32'h34, 1'b0, 4'hF, 32'h0);
    step(6);
    @(negedge clk_i);
    chk("bp_rsp_valid", rsp_valid_o,  1'b1);
    chk("bp_rready",    obi_rready_o, 1'b0);
    chk("bp_rdata",     rsp_rdata_o,  init_word(12));
    rr_pct = 100;
    @(negedge clk_i);
    chk("bp_rready_up", obi_rready_o, 1'b1);
    @(negedge clk_i);
    chk("bp_next_valid", rsp_valid_o, 1'b1);
    chk("bp_next_rdata", rsp_rdata_o, init_word(13));
    wait_idle();

    // spurious rvalid
    chk("proto_clear", proto_err_o, 1'b0);
    spur_req++;
    step(3);
    @(negedge clk_i);
    chk("spur_proto", proto_err_o, 1'b1);
    chk("spur_rsp",   rsp_valid_o, 1'b0);
    chk("spur_busy",  busy_o,      1'b0);

    // reset in the middle of a transaction
    rv_pct = 0;
    send(32'h38, 1'b0, 4'hF, 32'h0);
    step(1);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_reset("midrst");
    rv_pct = 100;
    step(4);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      if (i % 50 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        rv_pct  = $urandom_range(30, 100);
        rr_pct  = $urandom_range(30, 100);
      end
      idx = 5'($urandom_range(0, 31));
      send({25'h0, idx, 2'b00}, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
      step($urandom_range(0, 2));
    end
    gnt_pct = 100;
    rv_pct  = 100;
    rr_pct  = 100;
    wait_idle();
    chk("final_busy", busy_o, 1'b0);
    chk("final_proto", proto_err_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
